// File: rtl/cipher_pkg.sv
// Shared widths, character range and loader state encoding for the cipher machine.
// Imported by the string loader and by the downstream Caesar/Vigenere engine.
package cipher_pkg;

    localparam int CHAR_W    = 5;
    localparam int MAX_CHARS = 5;
    localparam int STR_W     = 25;
    localparam int CNT_W     = 3;

    localparam logic [CHAR_W-1:0] CHAR_A = 5'd1;
    localparam logic [CHAR_W-1:0] CHAR_Z = 5'd26;

    typedef enum logic {
        COLLECT = 1'b0,
        OFFER   = 1'b1
    } loader_state_e;

    function automatic logic is_letter(input logic [CHAR_W-1:0] code);
        return (code >= CHAR_A) && (code <= CHAR_Z);
    endfunction

endpackage

// File: rtl/key_conditioner.sv
// Turns a raw active-low key into a single-cycle press pulse: 2-flop sync, optional
// debounce (compiled in with CHAR_LOADER_DEBOUNCE_EN), then falling-edge detect.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic prev_d;
    logic press_q;
    logic press_d;
    logic level;

`ifdef CHAR_LOADER_DEBOUNCE_EN
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            level_q;
    logic            level_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;

    // Down-counter reloads whenever the synced key agrees with the accepted level.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = DB_LOAD;
        if (sync2_q != level_q) begin
            if (db_cnt_q == '0) begin
                level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q - DB_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q  <= 1'b1;
            db_cnt_q <= DB_LOAD;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level = level_q;
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign level = sync2_q;
`endif

    always_comb begin
        prev_d  = level;
        press_d = prev_q & ~level;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/char_string_loader.sv
// Collects up to five validated character codes into a packed string and offers it
// downstream on valid/ready. Key debounce is enabled by defining CHAR_LOADER_DEBOUNCE_EN.
module char_string_loader
    import cipher_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              load_n,
    input  logic              commit,
    input  logic              str_ready,
    output logic              str_valid,
    output logic [STR_W-1:0]  str_data,
    output logic [CNT_W-1:0]  char_count,
    output logic              full,
    output logic              reject
);

    logic press;

    key_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_conditioner (
        .clock (clock),
        .reset (reset),
        .key_n (load_n),
        .press (press)
    );

    loader_state_e      state_q,  state_d;
    logic [STR_W-1:0]   data_q,   data_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               valid_q,  valid_d;
    logic               full_q,   full_d;
    logic               reject_q, reject_d;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        count_d  = count_q;
        reject_d = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (press) begin
                    if (is_letter(char_in) && !full_q) begin
                        data_d  = {data_q[STR_W-CHAR_W-1:0], char_in};
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                // Commit sees the post-load count so a same-cycle load is included.
                if (commit && (count_d != '0)) begin
                    state_d = OFFER;
                end
            end
            OFFER: begin
                reject_d = press;
                if (valid_q && str_ready) begin
                    data_d  = '0;
                    count_d = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        valid_d = (state_d == OFFER);
        full_d  = (count_d == CNT_W'(MAX_CHARS));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= COLLECT;
            data_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            reject_q <= reject_d;
        end
    end

    assign str_valid  = valid_q;
    assign str_data   = data_q;
    assign char_count = count_q;
    assign full       = full_q;
    assign reject     = reject_q;

endmodule

// File: tb/tb_char_string_loader.sv
// Directed bench for char_string_loader: queue-based reference model compared every
// cycle, plus literal expectations taken from hand-worked examples.
module tb_char_string_loader;

    localparam int DB = 16;
`ifdef CHAR_LOADER_DEBOUNCE_EN
    localparam int DB_EN = 1;
`else
    localparam int DB_EN = 0;
`endif
    localparam int RUN_LEN   = DB_EN ? DB : 1;   // samples needed to accept a level change
    localparam int APPLY_LAT = DB_EN ? 4 : 3;    // edges from acceptance sample to buffer update
    localparam int PRESS_OFS = DB_EN ? 19 : 3;   // edges from first low sample to buffer update
    localparam int HOLD      = DB_EN ? 20 : 2;
    localparam int SETTLE    = DB_EN ? 26 : 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  char_in = 5'd0;
    logic        load_n = 1'b1;
    logic        commit = 1'b0;
    logic        str_ready = 1'b0;
    logic        str_valid;
    logic [24:0] str_data;
    logic [2:0]  char_count;
    logic        full;
    logic        reject;

    always #5 clock = ~clock;

    char_string_loader #(.DEBOUNCE_CYCLES(DB)) dut (
        .clock      (clock),
        .reset      (reset),
        .char_in    (char_in),
        .load_n     (load_n),
        .commit     (commit),
        .str_ready  (str_ready),
        .str_valid  (str_valid),
        .str_data   (str_data),
        .char_count (char_count),
        .full       (full),
        .reject     (reject)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a list of buffered characters and an offer flag.
    int cyc = 0;
    bit m_init = 0;
    int m_chars[$];
    bit m_offer = 0;
    bit m_rej = 0;
    bit m_acc = 1;
    int m_run = 0;
    int m_due[$];

    function automatic logic [31:0] model_data();
        logic [31:0] d;
        d = 0;
        foreach (m_chars[i]) d = (d << 5) | m_chars[i];
        return d;
    endfunction

    always @(posedge clock) begin
        bit pr;
        cyc++;
        if (reset) begin
            m_chars.delete();
            m_due.delete();
            m_offer = 0;
            m_rej = 0;
            m_acc = 1;
            m_run = 0;
            m_init = 1;
        end else begin
            if (load_n != m_acc) begin
                m_run++;
                if (m_run == RUN_LEN) begin
                    m_acc = load_n;
                    m_run = 0;
                    if (!load_n) m_due.push_back(cyc + APPLY_LAT);
                end
            end else begin
                m_run = 0;
            end
            pr = (m_due.size() > 0) && (m_due[0] == cyc);
            if (pr) void'(m_due.pop_front());
            m_rej = 0;
            if (!m_offer) begin
                if (pr) begin
                    if (char_in >= 1 && char_in <= 26 && m_chars.size() < 5) m_chars.push_back(int'(char_in));
                    else m_rej = 1;
                end
                if (commit && m_chars.size() > 0) m_offer = 1;
            end else begin
                if (pr) m_rej = 1;
                if (str_ready) begin
                    m_chars.delete();
                    m_offer = 0;
                end
            end
        end
    end

    int rej_seen = 0;
    int valid_cycles = 0;

    always @(negedge clock) begin
        if (m_init) begin
            check("str_valid", str_valid, m_offer);
            check("str_data", str_data, model_data());
            check("char_count", char_count, m_chars.size());
            check("full", full, m_chars.size() == 5);
            check("reject", reject, m_rej);
            if (reject === 1'b1) rej_seen++;
            if (str_valid === 1'b1) valid_cycles++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic press_hold(input logic [4:0] ch, input int hold);
        char_in = ch;
        load_n = 1'b0;
        tick(hold);
        load_n = 1'b1;
        tick(SETTLE);
    endtask

    task automatic press_key(input logic [4:0] ch);
        press_hold(ch, HOLD);
    endtask

    initial begin
        int r0;
        int v0;

        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("reset_valid", str_valid, 0);
        check("reset_data", str_data, 0);
        check("reset_count", char_count, 0);
        check("reset_full", full, 0);
        check("reset_reject", reject, 0);

        // c, a, b packed with the newest in the low slot
        press_key(5'd3);
        press_key(5'd1);
        press_key(5'd2);
        check("cab_data", str_data, 32'h000C22);
        check("cab_model", model_data(), 32'h000C22);
        check("cab_count", char_count, 3);

        press_key(5'd4);
        press_key(5'd5);
        check("five_full", full, 1);
        check("five_count", char_count, 5);
        check("five_data", str_data, 32'h308885);

        r0 = rej_seen;
        press_key(5'd7);
        check("full_reject_pulses", rej_seen - r0, 1);
        check("full_data_held", str_data, 32'h308885);
        check("full_count_held", char_count, 5);

        str_ready = 1'b1;
        commit = 1'b1;
        tick(1);
        commit = 1'b0;
        tick(2);
        str_ready = 1'b0;
        check("drain_valid", str_valid, 0);
        check("drain_count", char_count, 0);
        check("drain_data", str_data, 0);

        r0 = rej_seen;
        press_key(5'd0);
        press_key(5'd27);
        check("bad_code_rejects", rej_seen - r0, 2);
        check("bad_code_count", char_count, 0);

        // 'z' offered while the engine stalls for four cycles
        press_key(5'd26);
        v0 = valid_cycles;
        commit = 1'b1;
        tick(1);
        commit = 1'b0;
        tick(4);
        check("offer_valid", str_valid, 1);
        check("offer_data", str_data, 26);
        str_ready = 1'b1;
        tick(1);
        str_ready = 1'b0;
        tick(1);
        check("stall_valid_cycles", valid_cycles - v0, 5);
        check("xfer_valid", str_valid, 0);
        check("xfer_data", str_data, 0);
        check("xfer_count", char_count, 0);

        commit = 1'b1;
        tick(1);
        commit = 1'b0;
        tick(2);
        check("empty_commit_valid", str_valid, 0);

        // press and commit land on the same edge
        char_in = 5'd5;
        load_n = 1'b0;
        tick(PRESS_OFS);
        commit = 1'b1;
        load_n = 1'b1;
        tick(1);
        commit = 1'b0;
        tick(1);
        check("same_cycle_valid", str_valid, 1);
        check("same_cycle_data", str_data, 5);
        check("same_cycle_count", char_count, 1);

        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("offer_reset_valid", str_valid, 0);
        check("offer_reset_count", char_count, 0);
        check("offer_reset_data", str_data, 0);
        tick(SETTLE);

`ifdef CHAR_LOADER_DEBOUNCE_EN
        r0 = rej_seen;
        press_hold(5'd9, 10);
        check("glitch_count", char_count, 0);
        check("glitch_rejects", rej_seen - r0, 0);
        press_hold(5'd9, 40);
        check("long_hold_count", char_count, 1);
        check("long_hold_data", str_data, 9);
`else
        press_hold(5'd9, 1);
        check("short_pulse_count", char_count, 1);
        check("short_pulse_data", str_data, 9);
`endif

        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/char_string_loader.md
# char_string_loader

Upstream input stage of the cipher machine. Conditions the raw active-low load key, validates each 5-bit character code from the switches, and packs up to five characters into a zero-terminated 25-bit string. On a commit request it offers that string to the Caesar/Vigenère engine over a valid/ready handshake. It replaces the ad-hoc `char_array` register in the top level.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: the number of consecutive stable samples required before a key level change is accepted. Use 16 in simulation and 500000 on the board.

Ports (name, direction, width, meaning):
- `clock`, in, 1: system clock (CLOCK_50).
- `reset`, in, 1: synchronous, active-high. Clears all state.
- `char_in`, in, 5: character code. 'a' = 1 through 'z' = 26.
- `load_n`, in, 1: raw key, active-low, asynchronous to `clock`. A press loads `char_in`.
- `commit`, in, 1: one-cycle pulse, already synchronised. Requests that the buffered string be sent.
- `str_ready`, in, 1: the cipher engine can accept a string.
- `str_valid`, out, 1: `str_data` holds a committed string.
- `str_data`, out, 25: packed string. The newest character is in [4:0]. Unused slots are 0.
- `char_count`, out, 3: number of characters buffered, 0 to 5.
- `full`, out, 1: `char_count == 5`.
- `reject`, out, 1: one-cycle pulse when an accepted press is discarded.

## Operation
- Reset values: `str_valid=0`, `str_data=0`, `char_count=0`, `full=0`, `reject=0`, state COLLECT, key conditioner idle (key treated as released).
- Key conditioning: a 2-flop synchroniser, then an optional debounce stage, then a falling-edge detector. The detector produces `press`, a one-cycle pulse per physical press. A held key produces only one `press`.
- State COLLECT, on `press`:
  - `char_in` in 1..26 and `full=0`: set `str_data <= {str_data[19:0], char_in}` and `char_count += 1`.
  - `char_in` is 0 or in 27..31: buffer unchanged, `reject` pulses.
  - `full=1`: buffer unchanged, `reject` pulses.
- State COLLECT, on `commit`:
  - `char_count > 0`: go to OFFER.
  - `char_count == 0`: ignore.
- `press` and `commit` in the same cycle: the load is applied first, and the commit evaluates the post-load count. The string offered therefore includes the new character. A commit with count 0 plus a valid load goes to OFFER with count 1.
- State OFFER:
  - `str_valid=1`. `str_data` is held stable.
  - Every `press` is discarded and pulses `reject`.
  - `commit` is ignored.
- Handshake: a transfer occurs on a rising edge where `str_valid && str_ready`. On that edge: `str_data <= 0`, `char_count <= 0`, state goes to COLLECT, and `str_valid` is 0 in the next cycle.
- Reset in OFFER: the string is dropped and all outputs return to their reset values after that edge. No transfer occurs.
- The counter saturates at 5 and never wraps. There is no wrap-around in packing: the oldest character is never shifted out.

## Timing
- All outputs are registered.
- Load latency with debounce disabled: `load_n` first sampled low at edge t gives `press` high during cycle t+2. `str_data`/`char_count` update at edge t+3.
- Load latency with debounce enabled: the update occurs DEBOUNCE_CYCLES edges later than the non-debounce case.
- Commit latency: `commit` high at edge t, with count > 0, gives `str_valid` high from edge t+1.
- `str_ready` may be high before `str_valid`. The transfer then completes one cycle after `str_valid` rises.
- Throughput: at most one string per 2 cycles.

## Configuration
- `CHAR_LOADER_DEBOUNCE_EN` defined:
  - The debounce counter is compiled in.
  - The synchronised level must stay unchanged for DEBOUNCE_CYCLES consecutive edges before the accepted level changes.
  - Glitches shorter than that produce no `press`.
- Not defined:
  - The debounce counter is omitted. The edge detector uses the synchroniser output directly.
  - Every synchronised falling edge produces a `press`.
  - `DEBOUNCE_CYCLES` is unused.

## Structure
- Shared package `cipher_pkg`:
  - Constants: `CHAR_W=5`, `MAX_CHARS=5`, `STR_W=25`, `CHAR_A=1`, `CHAR_Z=26`.
  - The loader state enum (COLLECT, OFFER).
  - The downstream engine imports the same width constants.
- Sub-module `key_conditioner`:
  - Contains the synchroniser, the optional debounce and the falling-edge detector.
  - Inputs: `clock`, `reset`, `key_n`.
  - Output: `press`.
  - Reused later for the go and verify keys.

## Test plan
- Reset, then press with `char_in` = 3, 1, 2 (debounce off) → `str_data=0x00_0C22` (c,a,b packed as 00011_00001_00010), `char_count=3`. Each update lands 3 edges after the press.
- Five valid presses, then a sixth with `char_in=7` → `full=1`, `str_data` unchanged, `reject` pulses for exactly one cycle.
- Press with `char_in=0`, then with `char_in=27` → two `reject` pulses, `char_count` stays 0.
- Load 'z' (26), then commit with `str_ready=0` for 4 cycles, then `str_ready=1` → `str_valid` is high for 5 cycles with `str_data=26`. After the transfer, `str_valid=0`, `str_data=0`, `char_count=0`.
- Commit with count 0 → no `str_valid`. Same-cycle `press` (`char_in=5`) and `commit` with count 0 → OFFER with `str_data=5`, `char_count=1`.
- Debounce on, DEBOUNCE_CYCLES=16:
  - A 10-cycle low glitch on `load_n` → no load.
  - A 40-cycle low hold → exactly one load.
  - Reset asserted mid-OFFER → `str_valid=0` and `char_count=0` on the next cycle.
